bsg_rx: RTL

BSG_RX -- requirements
Module: bsg_rx

---
 rtl/bsg_rx_if.sv | 11 +
 rtl/bsg_rx.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/bsg_rx_if.sv
// rtl/bsg_rx_if.sv - register bus interface for the bsg_rx receiver
interface bsg_rx_if;
    logic [7:0] Data_in;
    logic [7:0] addr;
    logic       en;
    logic       we;
    logic [7:0] Data_out;

    modport master (output Data_in, addr, en, we, input Data_out);
    modport slave  (input Data_in, addr, en, we, output Data_out);
endinterface

// File: rtl/bsg_rx.sv
// rtl/bsg_rx.sv - Gray-coded symbol receiver with sync-byte lock, FIFO and register bus
module bsg_rx #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic       SYS_CLK,
    input  logic       SYS_RST_N,
    input  logic       RX_CLK_IN,
    input  logic [7:0] RX_IN,
    output logic       RX_INT,
    bsg_rx_if.slave    bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = AW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_OFF, S_HUNT, S_LOCK} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_rxen, r_intmsk, r_intflag, r_ovr;
    logic [7:0]      r_sync;
    logic            r_sync1, r_sync2, r_hist;
    logic [7:0]      r_dec;
    logic            r_dec_vld;
    logic [CW-1:0]   r_idle;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [LW-1:0]   r_level;

    logic       w_wr, w_rd, w_wr_ctrl, w_flush, w_edge;
    logic       w_empty, w_full, w_lock;
    logic       w_push_req, w_push, w_pop, w_ovr_set;
    logic [7:0] w_dec;

    assign w_wr      = bus.en & ~bus.we;
    assign w_rd      = bus.en & bus.we;
    assign w_wr_ctrl = w_wr & (bus.addr == 8'h00);
    assign w_flush   = w_wr_ctrl & ~bus.Data_in[0];
    assign w_edge    = r_sync2 & ~r_hist;
    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == LW'(DEPTH));
    assign w_lock    = (r_state == S_LOCK);

    assign w_push_req = w_lock & r_dec_vld & ~w_flush;
    assign w_pop      = w_rd & (bus.addr == 8'h01) & ~w_empty & ~w_flush;
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_ovr_set  = w_push_req & w_full & ~w_pop;

    // Bit i of binary is the XOR of Gray bits i..7.
    always_comb begin
        w_dec = '0;
        for (int i = 0; i < 8; i++) begin
            w_dec[i] = ^(RX_IN >> i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!r_rxen) begin
            w_state_nxt = S_OFF;
        end else begin
            case (r_state)
                S_OFF:   w_state_nxt = S_HUNT;
                S_HUNT:  if (r_dec_vld && r_dec == r_sync) w_state_nxt = S_LOCK;
                S_LOCK:  if (r_idle == CW'(TIMEOUT)) w_state_nxt = S_HUNT;
                default: w_state_nxt = S_OFF;
            endcase
        end
    end

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) r_state <= S_OFF;
        else            r_state <= w_state_nxt;
    end

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            r_rxen    <= 1'b0;
            r_intmsk  <= 1'b0;
            r_intflag <= 1'b0;
            r_ovr     <= 1'b0;
            r_sync    <= 8'hD5;
        end else begin
            if (w_wr_ctrl) begin
                r_rxen   <= bus.Data_in[0];
                r_intmsk <= bus.Data_in[1];
            end
            // Hardware set wins over a same-cycle write-1-clear.
            if (w_push)                            r_intflag <= 1'b1;
            else if (w_wr_ctrl && bus.Data_in[2])  r_intflag <= 1'b0;
            if (w_ovr_set)                         r_ovr <= 1'b1;
            else if (w_wr_ctrl && bus.Data_in[3])  r_ovr <= 1'b0;
            if (w_wr && bus.addr == 8'h02)         r_sync <= bus.Data_in;
        end
    end

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_hist    <= 1'b0;
            r_dec     <= '0;
            r_dec_vld <= 1'b0;
            r_idle    <= '0;
        end else if (w_flush) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_hist    <= 1'b0;
            r_dec     <= '0;
            r_dec_vld <= 1'b0;
            r_idle    <= '0;
        end else begin
            r_sync1   <= RX_CLK_IN;
            r_sync2   <= r_sync1;
            r_hist    <= r_sync2;
            r_dec_vld <= w_edge & (r_state != S_OFF);
            if (w_edge) r_dec <= w_dec;
            if (!w_lock || w_edge)            r_idle <= '0;
            else if (r_idle != CW'(TIMEOUT))  r_idle <= r_idle + 1'b1;
        end
    end

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (!w_push && w_pop) r_level <= r_level - 1'b1;
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (w_push) r_mem[r_wptr] <= r_dec;
    end

    always_comb begin
        bus.Data_out = 8'h00;
        case (bus.addr)
            8'h00:   bus.Data_out = {2'b00, w_empty, w_lock, r_ovr, r_intflag, r_intmsk, r_rxen};
            8'h01:   if (!w_empty) bus.Data_out = r_mem[r_rptr];
            8'h02:   bus.Data_out = r_sync;
            8'h03:   bus.Data_out = 8'(r_level);
            default: bus.Data_out = 8'h00;
        endcase
    end

    assign RX_INT = r_intmsk & r_intflag;
endmodule
